// File: rtl/sorted_array_loader.sv
// Insertion-sorting loader that feeds the binary-search stage its buffer in ascending order.
// Optional SORT_PAD_EN: drain always emits NUM_DATA beats, padding unused slots with all-ones.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef NUM_DATA
`define NUM_DATA 16
`endif

module sorted_array_loader #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_DATA   = `NUM_DATA,
  parameter int CW         = $clog2(NUM_DATA) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  load_done
);

  localparam int AW = $clog2(NUM_DATA);

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_arr [NUM_DATA];
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_rdPtr;
  logic                  r_inReady;
  logic                  r_outValid;
  logic                  r_loadDone;

  logic [NUM_DATA-1:0]   w_gt;
  logic [DATA_WIDTH-1:0] w_ins [NUM_DATA];
  logic                  w_accept;
  logic                  w_fillEnd;
  logic                  w_outFire;
  logic                  w_lastBeat;
  logic [CW-1:0]         w_drainLen;
  logic [AW-1:0]         w_rdIdx;
  logic [DATA_WIDTH-1:0] w_elem;

  // Strict greater-than keeps duplicates stable: a new value lands after its equals.
  always_comb begin
    w_gt = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      w_gt[i] = (CW'(i) < r_count) && (r_arr[i] > in_data);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DATA; i++) begin
      w_ins[i] = r_arr[i];
    end
    if (w_gt[0] || (r_count == '0)) begin
      w_ins[0] = in_data;
    end
    for (int i = 1; i < NUM_DATA; i++) begin
      if (w_gt[i-1]) begin
        w_ins[i] = r_arr[i-1];
      end else if (w_gt[i] || (CW'(i) == r_count)) begin
        w_ins[i] = in_data;
      end
    end
  end

  assign w_accept  = (r_state == FILL) && in_valid && r_inReady;
  assign w_fillEnd = in_last || (r_count == CW'(NUM_DATA - 1));
  assign w_outFire = r_outValid && out_ready;
  assign w_rdIdx   = r_rdPtr[AW-1:0];

`ifdef SORT_PAD_EN
  assign w_drainLen = CW'(NUM_DATA);
  assign w_elem     = (r_rdPtr >= r_count) ? {DATA_WIDTH{1'b1}} : r_arr[w_rdIdx];
`else
  assign w_drainLen = r_count;
  assign w_elem     = r_arr[w_rdIdx];
`endif

  assign w_lastBeat = (r_rdPtr == (w_drainLen - CW'(1)));

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_DATA; i++) begin
        r_arr[i] <= w_ins[i];
      end
    end
  end

  // Control FSM; the array itself is never cleared, only count bounds its meaningful part.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_loadDone <= 1'b0;
    end else begin
      r_loadDone <= 1'b0;
      case (r_state)
        FILL: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_count <= r_count + CW'(1);
            if (w_fillEnd) begin
              r_state    <= DRAIN;
              r_inReady  <= 1'b0;
              r_outValid <= 1'b1;
              r_rdPtr    <= '0;
            end
          end
        end
        DRAIN: begin
          if (w_outFire) begin
            r_rdPtr <= r_rdPtr + CW'(1);
            if (w_lastBeat) begin
              r_state    <= DONE;
              r_outValid <= 1'b0;
              r_loadDone <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state   <= FILL;
          r_count   <= '0;
          r_rdPtr   <= '0;
          r_inReady <= 1'b1;
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_outValid ? w_elem : '0;
  assign count     = r_count;
  assign load_done = r_loadDone;

endmodule

// File: tb/tb_sorted_array_loader.sv
// Directed bench for sorted_array_loader; expectations adapt to SORT_PAD_EN.
module tb_sorted_array_loader;

  localparam int DW = 8;
  localparam int N  = 16;
  localparam int CW = 5;
`ifdef SORT_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          load_done;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] expData [N];

  always #5 clk = ~clk;

  sorted_array_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .load_done(load_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted input beat; back-to-back calls give one beat per cycle.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic last);
    checkOutput("in_ready_fill", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drains a frame of n real elements held in expData, with optional stall and input noise.
  task automatic drainExpect(input int n, input int stallAt, input int stallCycles, input bit inject);
    int            len;
    logic [DW-1:0] e;
    len = PAD ? N : n;
    out_ready = 1'b1;
    if (inject) begin
      in_valid = 1'b1;
      in_data  = 8'd1;
    end
    for (int k = 0; k < len; k++) begin
      e = (k < n) ? expData[k] : 8'hFF;
      if (k == stallAt) begin
        out_ready = 1'b0;
        for (int s = 0; s < stallCycles; s++) begin
          checkOutput("stall_valid", 32'(out_valid), 32'd1);
          checkOutput("stall_data", 32'(out_data), 32'(e));
          tick();
        end
        out_ready = 1'b1;
      end
      checkOutput("drain_valid", 32'(out_valid), 32'd1);
      checkOutput("drain_data", 32'(out_data), 32'(e));
      checkOutput("in_ready_drain", 32'(in_ready), 32'd0);
      checkOutput("load_done_early", 32'(load_done), 32'd0);
      if (k == 0 || k == len - 1) begin
        checkOutput("drain_count", 32'(count), 32'(n));
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("load_done", 32'(load_done), 32'd1);
    checkOutput("done_out_valid", 32'(out_valid), 32'd0);
    checkOutput("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    tick();
    checkOutput("load_done_pulse", 32'(load_done), 32'd0);
    checkOutput("refill_in_ready", 32'(in_ready), 32'd1);
    checkOutput("refill_count", 32'(count), 32'd0);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Duplicates and basic ordering.
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd2, 1'b0);
    applyStimulus(8'd9, 1'b0);
    applyStimulus(8'd2, 1'b1);
    expData[0] = 8'd2; expData[1] = 8'd2; expData[2] = 8'd5; expData[3] = 8'd9;
    drainExpect(4, -1, 0, 1'b0);

    // Full array without in_last: auto transition to drain.
    for (int v = 15; v >= 0; v--) begin
      applyStimulus(8'(v), 1'b0);
    end
    for (int k = 0; k < N; k++) begin
      expData[k] = 8'(k);
    end
    drainExpect(16, -1, 0, 1'b0);

    // Backpressure on the second element.
    applyStimulus(8'd7, 1'b0);
    applyStimulus(8'd3, 1'b0);
    applyStimulus(8'd7, 1'b1);
    expData[0] = 8'd3; expData[1] = 8'd7; expData[2] = 8'd7;
    drainExpect(3, 1, 3, 1'b0);

    // Input activity during drain must be ignored.
    applyStimulus(8'd200, 1'b0);
    applyStimulus(8'd10, 1'b0);
    applyStimulus(8'd100, 1'b1);
    expData[0] = 8'd10; expData[1] = 8'd100; expData[2] = 8'd200;
    drainExpect(3, -1, 0, 1'b1);

    // Reset in the middle of a drain abandons the frame.
    applyStimulus(8'd6, 1'b0);
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd3, 1'b1);
    out_ready = 1'b1;
    checkOutput("abort_beat0", 32'(out_data), 32'd1);
    tick();
    checkOutput("abort_beat1", 32'(out_data), 32'd3);
    tick();
    checkOutput("abort_beat2", 32'(out_data), 32'd6);
    rst_n = 1'b0;
    tick();
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out_data", 32'(out_data), 32'd0);
    checkOutput("abort_count", 32'(count), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort_load_done", 32'(load_done), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick();
    checkOutput("abort_ready_back", 32'(in_ready), 32'd1);
    checkOutput("abort_no_done", 32'(load_done), 32'd0);
    applyStimulus(8'd4, 1'b1);
    expData[0] = 8'd4;
    drainExpect(1, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
